// File: rtl/calc_pkg.sv
// Shared types for the N-port calculator engine: command and response
// encodings plus the per-port request FSM states.
package calc_pkg;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE    = 2'b00,
    RESP_OK      = 2'b01,
    RESP_FLOW    = 2'b10,
    RESP_INVALID = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    PEND,
    FLIGHT
  } port_state_e;

endpackage

// File: rtl/calc_nport_engine_if.sv
// Flat per-port request/response bundle of the calculator engine.
// The requester side drives commands and operands; the engine answers.
interface calc_nport_engine_if
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*RESP_W-1:0] out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS-1:0]        out_busy;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, out_busy
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, out_busy
  );

endinterface

// File: rtl/calc_alu.sv
// Combinational ALU shared by all ports: add/sub with overflow detection,
// logical shifts, and an invalid-command response for everything else.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  output resp_e             resp_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [SH_W-1:0] sh_amt;

  assign sum    = {1'b0, op1_i} + {1'b0, op2_i};
  assign sh_amt = op2_i[SH_W-1:0];

  // NOTE: every output gets a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    resp_o = RESP_INVALID;
    data_o = '0;
    case (cmd_i)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          resp_o = RESP_FLOW;
        end else begin
          resp_o = RESP_OK;
          data_o = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op1_i < op2_i) begin
          resp_o = RESP_FLOW;
        end else begin
          resp_o = RESP_OK;
          data_o = op1_i - op2_i;
        end
      end
      CMD_SHL: begin
        resp_o = RESP_OK;
        data_o = op1_i << sh_amt;
      end
      CMD_SHR: begin
        resp_o = RESP_OK;
        data_o = op1_i >> sh_amt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_nport_engine.sv
// NUM_PORTS request channels feeding one ALU stage through a round-robin
// arbiter; each port takes cmd+op1, then op2, and answers 4 cycles later.
module calc_nport_engine
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input logic               c_clk,
  input logic               reset,
  calc_nport_engine_if.slave bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [CMD_W-1:0]  port_cmd  [NUM_PORTS];
  logic [DATA_W-1:0] port_data [NUM_PORTS];

  port_state_e       state_q [NUM_PORTS];
  logic [CMD_W-1:0]  cmd_q   [NUM_PORTS];
  logic [DATA_W-1:0] op1_q   [NUM_PORTS];
  logic [DATA_W-1:0] op2_q   [NUM_PORTS];

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  int                scan_idx;

  logic              s1_valid_q;
  logic [PTR_W-1:0]  s1_port_q;
  logic [CMD_W-1:0]  s1_cmd_q;
  logic [DATA_W-1:0] s1_op1_q, s1_op2_q;

  resp_e             alu_resp;
  logic [DATA_W-1:0] alu_data;

  logic [NUM_PORTS*RESP_W-1:0] out_resp_q;
  logic [NUM_PORTS*DATA_W-1:0] out_data_q;
  logic [NUM_PORTS-1:0]        busy;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign port_cmd[g]  = bus.req_cmd_in[CMD_W*g +: CMD_W];
    assign port_data[g] = bus.req_data_in[DATA_W*g +: DATA_W];
  end

  // First PEND port at or after rr_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_PORTS) scan_idx = scan_idx - NUM_PORTS;
      if (!grant_any && state_q[scan_idx] == PEND) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
  end

  calc_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd_i  (s1_cmd_q),
    .op1_i  (s1_op1_q),
    .op2_i  (s1_op2_q),
    .resp_o (alu_resp),
    .data_o (alu_data)
  );

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= IDLE;
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_port_q  <= '0;
      out_resp_q <= '0;
      out_data_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (state_q[p])
          IDLE:    if (port_cmd[p] != CMD_NOP) state_q[p] <= OP2;
          OP2:     state_q[p] <= PEND;
          PEND:    if (grant_any && grant_idx == PTR_W'(p)) state_q[p] <= FLIGHT;
          FLIGHT:  if (s1_valid_q && s1_port_q == PTR_W'(p)) state_q[p] <= IDLE;
          default: state_q[p] <= IDLE;
        endcase

        // Output register holds a result for exactly one cycle.
        out_resp_q[RESP_W*p +: RESP_W] <= RESP_NONE;
        out_data_q[DATA_W*p +: DATA_W] <= '0;
        if (s1_valid_q && s1_port_q == PTR_W'(p)) begin
          out_resp_q[RESP_W*p +: RESP_W] <= alu_resp;
          out_data_q[DATA_W*p +: DATA_W] <= alu_data;
        end
      end
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= grant_any;
      s1_port_q  <= grant_idx;
    end
  end

  // NOTE: operand and command storage carries no reset; its contents only
  // matter while the matching state/valid bit says so, and those are reset.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state_q[p] == IDLE && port_cmd[p] != CMD_NOP) begin
        cmd_q[p] <= port_cmd[p];
        op1_q[p] <= port_data[p];
      end
      if (!reset && state_q[p] == OP2) op2_q[p] <= port_data[p];
    end
    if (grant_any) begin
      s1_cmd_q <= cmd_q[grant_idx];
      s1_op1_q <= op1_q[grant_idx];
      s1_op2_q <= op2_q[grant_idx];
    end
  end

  always_comb begin
    busy = '0;
    for (int p = 0; p < NUM_PORTS; p++) busy[p] = (state_q[p] != IDLE);
  end

  assign bus.out_resp = out_resp_q;
  assign bus.out_data = out_data_q;
  assign bus.out_busy = busy;

endmodule

// File: tb/tb_calc_nport_engine.sv
// Self-checking bench: a cycle-stamped transaction model predicts every
// port's outputs each cycle; directed sequences pin exact literal results.
module tb_calc_nport_engine;

  localparam int NP = 4;
  localparam int DW = 32;

  logic c_clk = 1'b0;
  logic reset;

  always #5 c_clk = ~c_clk;

  calc_nport_engine_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  calc_nport_engine #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic, straight from the command definitions.
  function automatic void ref_calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   output logic [1:0] r, output logic [31:0] d);
    r = 2'b11;
    d = '0;
    case (cmd)
      4'd1: if (64'(a) + 64'(b) > 64'(32'hFFFF_FFFF)) r = 2'b10;
            else begin r = 2'b01; d = a + b; end
      4'd2: if (a < b) r = 2'b10;
            else begin r = 2'b01; d = a - b; end
      4'd5: begin r = 2'b01; d = a << (b % DW); end
      4'd6: begin r = 2'b01; d = a >> (b % DW); end
      default: ;
    endcase
  endfunction

  // Model: each port has at most one outstanding request, stamped with the
  // cycle it was accepted and the cycle its answer must be visible.
  int          acc_cyc [NP];
  int          rsp_cyc [NP];
  logic [3:0]  m_cmd   [NP];
  logic [31:0] m_op1   [NP];
  logic [31:0] m_op2   [NP];
  logic [1:0]  m_r     [NP];
  logic [31:0] m_d     [NP];
  int          m_rr  = 0;
  int          cyc   = 0;
  bit          chk_en = 1'b0;
  logic [1:0]  exp_resp [NP];
  logic [31:0] exp_data [NP];
  logic        exp_busy [NP];

  function automatic bit m_busy(int p, int c);
    return acc_cyc[p] >= 0 && (rsp_cyc[p] < 0 || c < rsp_cyc[p]);
  endfunction

  always @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        acc_cyc[p] = -1; rsp_cyc[p] = -1;
        exp_resp[p] = '0; exp_data[p] = '0; exp_busy[p] = 1'b0;
      end
      m_rr = 0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      int granted;
      granted = -1;
      for (int p = 0; p < NP; p++)
        if (acc_cyc[p] >= 0 && acc_cyc[p] == cyc - 1) m_op2[p] = bus.req_data_in[DW*p +: DW];
      for (int i = 0; i < NP; i++) begin
        int q;
        q = (m_rr + i) % NP;
        if (granted < 0 && acc_cyc[q] >= 0 && acc_cyc[q] + 2 <= cyc && rsp_cyc[q] < 0) granted = q;
      end
      if (granted >= 0) begin
        rsp_cyc[granted] = cyc + 2;
        ref_calc(m_cmd[granted], m_op1[granted], m_op2[granted], m_r[granted], m_d[granted]);
        m_rr = (granted + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin
        if (!m_busy(p, cyc) && bus.req_cmd_in[4*p +: 4] != 4'd0) begin
          acc_cyc[p] = cyc;
          rsp_cyc[p] = -1;
          m_cmd[p]   = bus.req_cmd_in[4*p +: 4];
          m_op1[p]   = bus.req_data_in[DW*p +: DW];
        end
      end
      for (int p = 0; p < NP; p++) begin
        exp_busy[p] = m_busy(p, cyc + 1);
        exp_resp[p] = (rsp_cyc[p] == cyc + 1) ? m_r[p] : 2'b00;
        exp_data[p] = (rsp_cyc[p] == cyc + 1) ? m_d[p] : 32'd0;
      end
    end
    cyc++;
  end

  always @(negedge c_clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("model_resp[%0d]", p), 64'(bus.out_resp[2*p +: 2]), 64'(exp_resp[p]));
        check($sformatf("model_data[%0d]", p), 64'(bus.out_data[DW*p +: DW]), 64'(exp_data[p]));
        check($sformatf("model_busy[%0d]", p), 64'(bus.out_busy[p]), 64'(exp_busy[p]));
      end
    end
  end

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
    bus.req_cmd_in[4*p +: 4]    = c;
    bus.req_data_in[DW*p +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
  endtask

  task automatic pin(input string name, input int p, input logic [1:0] r, input logic [31:0] d);
    check({name, "_resp"}, 64'(bus.out_resp[2*p +: 2]), 64'(r));
    check({name, "_data"}, 64'(bus.out_data[DW*p +: DW]), 64'(d));
  endtask

  task automatic do_reset();
    tick(); clear_inputs(); reset = 1'b1;
    tick(); reset = 1'b0;
  endtask

  task automatic run_single(input string name, input int p, input logic [3:0] c,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] er, input logic [31:0] ed);
    tick(); set_port(p, c, a);
    tick(); set_port(p, 4'd0, b);
    tick(); clear_inputs();
    tick();
    tick(); @(negedge c_clk); pin(name, p, er, ed);
    tick(); @(negedge c_clk); pin({name, "_after"}, p, 2'b00, 32'd0);
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'd0;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] cmd_tbl [10];
    cmd_tbl = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd9, 4'd15, 4'd4};
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(posedge c_clk);
    #1 reset = 1'b0;
    @(negedge c_clk);
    check("reset_resp", 64'(bus.out_resp), 64'd0);
    check("reset_data", 64'(bus.out_data), 64'd0);
    check("reset_busy", 64'(bus.out_busy), 64'd0);

    run_single("p0_add",      0, 4'd1, 32'h64,        32'h27, 2'b01, 32'h8B);
    run_single("p1_add_ovf",  1, 4'd1, 32'hFFFF_FFFF, 32'h1,  2'b10, 32'h0);
    run_single("p1_sub_unf",  1, 4'd2, 32'h22,        32'h23, 2'b10, 32'h0);
    run_single("p1_shl",      1, 4'd5, 32'h3,         32'h22, 2'b01, 32'hC);

    // All four ports in one cycle, twice back to back, from rr_ptr=0.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      tick(); set_port(0, 4'd1, 32'd1); set_port(1, 4'd2, 32'd5);
              set_port(2, 4'd6, 32'hC); set_port(3, 4'd9, 32'h1234);
      tick(); set_port(0, 4'd0, 32'd1); set_port(1, 4'd0, 32'd2);
              set_port(2, 4'd0, 32'd2); set_port(3, 4'd0, 32'h55);
      tick(); clear_inputs();
      tick();
      tick(); @(negedge c_clk); pin("cont_p0", 0, 2'b01, 32'd2);
      tick(); @(negedge c_clk); pin("cont_p1", 1, 2'b01, 32'd3);
      tick(); @(negedge c_clk); pin("cont_p2", 2, 2'b01, 32'd3);
      tick(); @(negedge c_clk); pin("cont_p3", 3, 2'b11, 32'd0);
    end

    // Command while busy is dropped; re-issue in the response cycle works.
    tick(); set_port(2, 4'd1, 32'd2);
    tick(); set_port(2, 4'd0, 32'd3);
    tick(); set_port(2, 4'd2, 32'd9);
    @(negedge c_clk); check("busy_p2_high", 64'(bus.out_busy[2]), 64'd1);
    tick(); set_port(2, 4'd0, 32'd1);
    tick(); set_port(2, 4'd2, 32'd9);
    @(negedge c_clk); pin("busy_first", 2, 2'b01, 32'd5);
    check("busy_p2_low", 64'(bus.out_busy[2]), 64'd0);
    tick(); set_port(2, 4'd0, 32'd1);
    @(negedge c_clk); pin("busy_none5", 2, 2'b00, 32'd0);
    tick(); clear_inputs();
    @(negedge c_clk); pin("busy_none6", 2, 2'b00, 32'd0);
    tick();
    tick(); @(negedge c_clk); pin("busy_reissue", 2, 2'b01, 32'd8);

    // Reset while the operation is in flight: nothing is ever answered.
    tick(); set_port(0, 4'd1, 32'd7);
    tick(); set_port(0, 4'd0, 32'd8);
    tick(); clear_inputs();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge c_clk);
    check("rst_fl_busy", 64'(bus.out_busy), 64'd0);
    check("rst_fl_data", 64'(bus.out_data), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick(); @(negedge c_clk); check("rst_fl_resp", 64'(bus.out_resp), 64'd0);
    end

    // Reset during the op2 cycle.
    tick(); set_port(1, 4'd1, 32'd4);
    tick(); set_port(1, 4'd0, 32'd4); reset = 1'b1;
    tick(); reset = 1'b0; clear_inputs();
    for (int i = 0; i < 6; i++) begin
      @(negedge c_clk); check("rst_op2_resp", 64'(bus.out_resp), 64'd0);
      check("rst_op2_busy", 64'(bus.out_busy), 64'd0);
      tick();
    end

    // No-ops never occupy a port.
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int p = 0; p < NP; p++) set_port(p, 4'd0, $urandom);
      @(negedge c_clk);
      check("nop_resp", 64'(bus.out_resp), 64'd0);
      check("nop_busy", 64'(bus.out_busy), 64'd0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0) set_port(p, cmd_tbl[$urandom_range(0, 9)], rnd_data());
        else set_port(p, 4'd0, rnd_data());
      end
    end
    tick(); reset = 1'b0; clear_inputs();
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
